// File: rtl/seg7_capture_pkg.sv
// Shared seven-segment display definitions: segment codes for the BCD encoder
// and the capture-side decoder, plus the capture FSM state type.
package seg7_capture_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    // Segment patterns, bit6..0 = a..g (dp excluded)
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_ERR   = 4'hF;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD lookup. Blank decodes to F without
// error; any unrecognised pattern decodes to F with err set.
module seg7_to_bcd
    import seg7_capture_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] code,
    output logic       err
);

    logic unused_dp;
    assign unused_dp = seg[7];

    always_comb begin
        code = BCD_ERR;
        err  = 1'b0;
        case (seg[6:0])
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = BCD_ERR;
            default:   err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed four-digit seven-segment display into BCD frames,
// debouncing each digit and presenting completed frames over valid/ready.
module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bcd_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  err_out,
    output logic        overrun
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    state_t      state, state_nxt;
    logic [7:0]  seg_q;
    logic [3:0]  sel_q;
    logic [3:0]  cnt;
    logic [3:0]  mask, mask_nxt;
    logic [15:0] sh_bcd, sh_bcd_nxt;
    logic [3:0]  sh_dp, sh_dp_nxt;
    logic [3:0]  sh_err, sh_err_nxt;

    logic        sel_ok, same, capture, frame_done, handshake;
    logic        load, ovr;
    logic [3:0]  cap_mask;
    logic [3:0]  dec_code;
    logic        dec_err;

    seg7_to_bcd u_dec (
        .seg  (seg_q),
        .code (dec_code),
        .err  (dec_err)
    );

    assign sel_ok     = $onehot(dig_sel);
    assign same       = ({seg_in, dig_sel} == {seg_q, sel_q});
    assign capture    = sel_ok && same && (cnt == CNT_MAX - 4'd1);
    assign cap_mask   = capture ? sel_q : '0;
    assign mask_nxt   = mask | cap_mask;
    assign frame_done = capture && (mask_nxt == 4'hF);
    assign handshake  = out_valid && out_ready;

    // The freshly captured digit is merged here so a completing frame loads
    // the outputs in the same edge that captures its last digit.
    always_comb begin
        sh_bcd_nxt = sh_bcd;
        sh_dp_nxt  = sh_dp;
        sh_err_nxt = sh_err;
        for (int unsigned i = 0; i < 4; i++) begin
            if (cap_mask[i]) begin
                sh_bcd_nxt[4*i +: 4] = dec_code;
                sh_dp_nxt[i]         = seg_q[7];
                sh_err_nxt[i]        = dec_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr       = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (frame_done) begin
                    load      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (frame_done) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end else if (frame_done) begin
                    ovr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= '0;
            sel_q     <= '0;
            cnt       <= '0;
            mask      <= '0;
            sh_bcd    <= '1;
            sh_dp     <= '0;
            sh_err    <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            bcd_out   <= '1;
            dp_out    <= '0;
            err_out   <= '0;
        end else begin
            seg_q <= seg_in;
            sel_q <= dig_sel;

            // The first sample of a new run counts as one, so a pattern
            // present for STABLE_CNT cycles is accepted.
            if (!sel_ok) begin
                cnt <= '0;
            end else if (!same) begin
                cnt <= 4'd1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 4'd1;
            end

            sh_bcd <= sh_bcd_nxt;
            sh_dp  <= sh_dp_nxt;
            sh_err <= sh_err_nxt;
            mask   <= frame_done ? '0 : mask_nxt;

            if (load) begin
                bcd_out <= sh_bcd_nxt;
                dp_out  <= sh_dp_nxt;
                err_out <= sh_err_nxt;
            end

            out_valid <= (state_nxt == ST_HOLD);
            overrun   <= ovr;
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with hand-computed expected frames.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_out;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int n_hs = 0;
    int n_ovr = 0;
    int hs0, ovr0;

    seg7_capture #(.STABLE_CNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .err_out   (err_out),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) n_hs++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        step(n);
    endtask

    task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        hold(s0, 4'b0001, 4);
        hold(s1, 4'b0010, 4);
        hold(s2, 4'b0100, 4);
        hold(s3, 4'b1000, 4);
    endtask

    initial begin
        // reset values, applied without a clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_ovr",   16'(overrun),   16'h0);
        chk("rst_bcd",   bcd_out,        16'hFFFF);
        chk("rst_dp",    16'(dp_out),    16'h0);
        chk("rst_err",   16'(err_out),   16'h0);
        step(2);
        rst = 1'b0;
        step(1);

        // basic frame 3210
        hs0 = n_hs;
        frame(8'h7E, 8'h30, 8'h6D, 8'h79);
        chk("f1_valid", 16'(out_valid), 16'h1);
        chk("f1_bcd",   bcd_out,        16'h3210);
        chk("f1_err",   16'(err_out),   16'h0);
        chk("f1_dp",    16'(dp_out),    16'h0);
        step(1);
        chk("f1_drop",  16'(out_valid), 16'h0);
        chk("f1_hs",    16'(n_hs - hs0), 16'h1);

        // short 3-cycle run on digit2 is ignored
        hold(8'h7E, 4'b0001, 4);
        hold(8'h30, 4'b0010, 4);
        hold(8'h5F, 4'b0100, 3);
        hold(8'h00, 4'b0000, 1);
        hold(8'h79, 4'b1000, 4);
        chk("short_novalid", 16'(out_valid), 16'h0);
        hold(8'h5F, 4'b0100, 4);
        chk("short_valid", 16'(out_valid), 16'h1);
        chk("short_bcd",   bcd_out,        16'h3610);
        step(1);

        // illegal pattern, blank, and dp on digit3
        frame(8'h7E, 8'h12, 8'h00, 8'hF9);
        chk("ill_valid", 16'(out_valid), 16'h1);
        chk("ill_bcd",   bcd_out,        16'h3FF0);
        chk("ill_err",   16'(err_out),   16'h2);
        chk("ill_dp",    16'(dp_out),    16'h8);
        step(1);

        // non-one-hot selects never capture
        hold(8'h7E, 4'b0011, 10);
        hold(8'h7E, 4'b0000, 10);
        hold(8'h30, 4'b0010, 4);
        hold(8'h6D, 4'b0100, 4);
        hold(8'h79, 4'b1000, 4);
        chk("sel_novalid", 16'(out_valid), 16'h0);
        hold(8'h5B, 4'b0001, 4);
        chk("sel_valid", 16'(out_valid), 16'h1);
        chk("sel_bcd",   bcd_out,        16'h3215);
        chk("sel_dp",    16'(dp_out),    16'h0);
        chk("sel_err",   16'(err_out),   16'h0);
        step(1);

        // back-pressure: second frame overruns and is discarded
        out_ready = 1'b0;
        ovr0 = n_ovr;
        frame(8'h7E, 8'h30, 8'h6D, 8'h79);
        chk("bp_valid", 16'(out_valid), 16'h1);
        chk("bp_bcd",   bcd_out,        16'h3210);
        frame(8'h7F, 8'h7B, 8'h70, 8'h33);
        chk("bp_ovr_hi", 16'(overrun),   16'h1);
        chk("bp_held",   bcd_out,        16'h3210);
        step(1);
        chk("bp_ovr_lo", 16'(overrun),   16'h0);
        chk("bp_ovr_n",  16'(n_ovr - ovr0), 16'h1);
        chk("bp_valid2", 16'(out_valid), 16'h1);
        hs0 = n_hs;
        out_ready = 1'b1;
        step(1);
        chk("bp_drop",  16'(out_valid),  16'h0);
        chk("bp_hs",    16'(n_hs - hs0), 16'h1);
        step(2);
        chk("bp_stay",  16'(out_valid),  16'h0);

        // handshake coincides with next frame completion
        out_ready = 1'b0;
        frame(8'h7E, 8'h30, 8'h6D, 8'h79);
        chk("co_valid", 16'(out_valid), 16'h1);
        hold(8'h5B, 4'b0001, 4);
        hold(8'h5F, 4'b0010, 4);
        hold(8'h70, 4'b0100, 4);
        hold(8'h7F, 4'b1000, 3);
        ovr0 = n_ovr;
        hs0 = n_hs;
        out_ready = 1'b1;
        step(1);
        chk("co_valid2", 16'(out_valid),    16'h1);
        chk("co_bcd",    bcd_out,           16'h8765);
        chk("co_ovr",    16'(n_ovr - ovr0), 16'h0);
        chk("co_hs",     16'(n_hs - hs0),   16'h1);
        step(1);
        chk("co_drop",   16'(out_valid),    16'h0);

        // asynchronous reset during HOLD with a partial frame pending
        out_ready = 1'b0;
        frame(8'h7E, 8'h30, 8'h6D, 8'h79);
        chk("ar_valid", 16'(out_valid), 16'h1);
        hold(8'h7F, 4'b0001, 4);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid0", 16'(out_valid), 16'h0);
        chk("ar_bcd",    bcd_out,        16'hFFFF);
        chk("ar_err",    16'(err_out),   16'h0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        step(3);
        hold(8'h30, 4'b0010, 4);
        hold(8'h6D, 4'b0100, 4);
        hold(8'h79, 4'b1000, 4);
        chk("ar_partial", 16'(out_valid), 16'h0);
        hold(8'h7F, 4'b0001, 4);
        chk("ar_valid1", 16'(out_valid), 16'h1);
        chk("ar_bcd2",   bcd_out,        16'h3218);
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CNT, default 4, consecutive identical sample cycles required before a digit is accepted (legal 2..15).
REQ-002 Port: clk  input  1  single system clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: seg_in  input  8  segment bus; bit7 = dp, bits6..0 = segments a..g.
REQ-005 Port: dig_sel  input  4  digit select; one-hot; bit0 = least significant digit.
REQ-006 Port: out_valid  output  1  captured frame available.
REQ-007 Port: out_ready  input  1  consumer accepts frame.
REQ-008 Port: bcd_out  output  16  four BCD digits; [3:0] = digit0.
REQ-009 Port: dp_out  output  4  captured dp bit per digit.
REQ-010 Port: err_out  output  4  per-digit flag: pattern was not a legal code.
REQ-011 Port: overrun  output  1  one-cycle pulse when a new frame completes while out_valid is held.

Function
REQ-012 Pattern table (bits6..0 -> BCD): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9; 00 (blank) -> F with err clear; any other pattern -> F with err set.
REQ-013 Sampling: {seg_in, dig_sel} registered each cycle; stability counter cleared when the current sample differs from the previous one or dig_sel is not one-hot, otherwise incremented, saturating at STABLE_CNT.
REQ-014 Acceptance: a digit is captured exactly once per stable run, in the cycle the counter transitions to STABLE_CNT; code, dp and err are written to that digit's shadow register and its mask bit is set.
REQ-015 Holding the same pattern beyond STABLE_CNT produces no further capture; a new capture requires a change and a new stable run.
REQ-016 State machine COLLECT/HOLD; COLLECT: when the mask becomes 4'b1111, shadow registers copy to bcd_out/dp_out/err_out, mask clears, out_valid asserts the next cycle, state -> HOLD.
REQ-017 HOLD: out_valid stays high and outputs stay constant until out_valid && out_ready; then out_valid drops the next cycle, state -> COLLECT.
REQ-018 In HOLD, captures continue into the shadow registers and mask; if the mask reaches 4'b1111 in HOLD, overrun pulses for one cycle, the mask clears, and that frame is discarded.
REQ-019 Handshake and frame completion in the same cycle: the handshake takes precedence; the completed frame is loaded and out_valid stays high without a low cycle.
REQ-020 A digit captured twice within one frame overwrites its shadow value; the mask is unaffected.

Reset
REQ-021 rst asserted: state=COLLECT, out_valid=0, overrun=0, bcd_out=16'hFFFF, dp_out=0, err_out=0, mask=0, counter=0, sample registers=0; takes effect immediately, independent of clk.
REQ-022 Reset mid-frame or during HOLD discards all partial and pending data; the first capture after reset requires a full STABLE_CNT run.

Structure
REQ-023 The ten segment constants, blank code and BCD error code F reside in the shared display package alongside the existing BCD-to-segment table, so that encoder and decoder share one source.
REQ-024 The combinational pattern lookup forms one sub-module, seg7_to_bcd (8-bit in; 4-bit code, err out); all sequential logic resides in seg7_capture.

Verification
REQ-025 Drive dig0..3 = 7E,30,6D,79, each held 4 cycles, out_ready=1 -> out_valid pulses once, bcd_out=16'h3210, err_out=0.
REQ-026 Hold digit2 = 5F for only 3 cycles, then 4 cycles -> only the second run captures; digit2 = 6.
REQ-027 Digit1 = 0x12 (illegal) with the others legal -> bcd_out[7:4]=F, err_out=4'b0010; a blank 00 gives F with err=0.
REQ-028 out_ready=0 while two full frames arrive -> first frame held unchanged, overrun pulses once, then out_ready=1 -> one handshake, out_valid drops.
REQ-029 dig_sel=4'b0011 or 4'b0000 for 10 cycles -> no capture; counter stays 0.
REQ-030 Assert rst asynchronously between clock edges during HOLD -> out_valid falls without a clock edge, bcd_out=FFFF, and the next frame requires four fresh captures.
